// File: rtl/ehl_buffer_wr_arbiter_pkg.sv
// Shared constants and helpers for the buffer write-port arbiter and its round-robin core.
package ehl_buffer_wr_arbiter_pkg;

  localparam int unsigned STALL_CNT_W = 8;
  localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = '1;

  // The source tag occupies the MSBs of buf_data, directly above the payload.
  function automatic int unsigned id_tag_lsb(int unsigned data_width);
    return data_width;
  endfunction

  function automatic int unsigned wrap_inc(int unsigned val, int unsigned n);
    return (val + 1 >= n) ? 0 : val + 1;
  endfunction

endpackage

// File: rtl/ehl_buffer_wr_arbiter_rr_arbiter.sv
// Round-robin arbiter core: combinational search from rr_ptr with wrap, owns the pointer.
module ehl_rr_arbiter
  import ehl_buffer_wr_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [PtrW-1:0] grant_idx
);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW:0]   cand;
  logic            found;

  always_comb begin
    grant     = '0;
    grant_idx = ptr_q;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (cand >= (PtrW+1)'(N)) cand = cand - (PtrW+1)'(N);
      if (!found && req[cand[PtrW-1:0]]) begin
        found                   = 1'b1;
        grant[cand[PtrW-1:0]]   = 1'b1;
        grant_idx               = cand[PtrW-1:0];
      end
    end
  end

  // Pointer only moves past a served requester, so a stalled grantee keeps priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= PtrW'(wrap_inc(32'(grant_idx), N));
    end
  end

endmodule

// File: rtl/ehl_buffer_wr_arbiter.sv
// Round-robin sharing of one buffer write port among N_REQ valid/ready requesters.
// Optional burst locking on req_last is enabled with `define EHL_BUF_ARB_LOCK_EN.
module ehl_buffer_wr_arbiter
  import ehl_buffer_wr_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [N_REQ-1:0]               req_valid,
  input  logic [N_REQ-1:0]               req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [N_REQ-1:0]               req_ready,
  input  logic                           buf_full,
  output logic                           buf_wr,
  output logic [DATA_WIDTH+ID_WIDTH-1:0] buf_data,
  output logic [ID_WIDTH-1:0]            grant_id,
  input  logic                           clear_err,
  output logic [N_REQ-1:0]               protocol_err,
  output logic [STALL_CNT_W-1:0]         stall_cnt
);

  localparam int unsigned PtrW  = $clog2(N_REQ);
  localparam int unsigned IdLsb = id_tag_lsb(DATA_WIDTH);

  if (N_REQ > 2**ID_WIDTH) begin : g_id_width_check
    $error("ehl_buffer_wr_arbiter: N_REQ exceeds 2**ID_WIDTH");
  end

  logic [N_REQ-1:0]       eligible;
  logic [N_REQ-1:0]       grant;
  logic [PtrW-1:0]        grant_idx;
  logic                   accept;
  logic [N_REQ-1:0]       pending_q, pending_d;
  logic [N_REQ-1:0]       err_q, err_d;
  logic [N_REQ-1:0]       violation;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

`ifdef EHL_BUF_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [PtrW-1:0] locked_id_q, locked_id_d;

  // While a burst is open only its owner is eligible, even if it drops valid.
  always_comb begin
    eligible = req_valid;
    if (lock_q) eligible = req_valid & (N_REQ'(1) << locked_id_q);
  end

  always_comb begin
    lock_d      = lock_q;
    locked_id_d = locked_id_q;
    if (accept) begin
      lock_d      = !req_last[grant_idx];
      locked_id_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_q      <= 1'b0;
      locked_id_q <= '0;
    end else begin
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
    end
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  ehl_rr_arbiter #(
    .N    (N_REQ),
    .PtrW (PtrW)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (eligible),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Full blocks every write, even when the buffer is being read this cycle.
  assign accept = reset_n & (|grant) & ~buf_full;

  always_comb begin
    req_ready = '0;
    buf_wr    = 1'b0;
    buf_data  = '0;
    grant_id  = '0;
    if (reset_n) begin
      grant_id = ID_WIDTH'(grant_idx);
      if (accept) begin
        req_ready                       = grant;
        buf_wr                          = 1'b1;
        buf_data[IdLsb +: ID_WIDTH]     = ID_WIDTH'(grant_idx);
        buf_data[DATA_WIDTH-1:0]        = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A requester left waiting must keep valid up until it is served.
  assign violation = pending_q & ~req_valid;

  always_comb begin
    pending_d = req_valid & ~req_ready;
    err_d     = clear_err ? violation : (err_q | violation);
    stall_d   = stall_q;
    if (clear_err) begin
      stall_d = '0;
    end else if ((|req_valid) && buf_full && (stall_q != STALL_CNT_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= '0;
      err_q     <= '0;
      stall_q   <= '0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
    end
  end

  assign protocol_err = err_q;
  assign stall_cnt    = stall_q;

endmodule
